// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared types and constants for the pong game sequencer.
//   state_e      : game sequencer states (IDLE, SERVE, PLAY, OVER)
//   WINNER_*     : encodings driven on Winner_o
//   SCORE_W      : width of each player's score
//   FRAME_CNT_W  : width of the serve-hold frame counter
// -----------------------------------------------------------------------------
package pong_pkg;

  localparam int SCORE_W     = 4;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_e;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

endpackage

// File: rtl/pong_edge_sync.sv
// -----------------------------------------------------------------------------
// pong_edge_sync
// Two-flop synchroniser followed by a single-cycle edge detector.
//   clk_i       : pixel clock
//   rst_n_i     : asynchronous active-low reset
//   async_i     : asynchronous input pin
//   edge_o      : one-cycle pulse on the selected edge of the synchronised input
// Parameters:
//   DETECT_RISE : 1 = pulse on rising edge, 0 = pulse on falling edge
//   RESET_VAL   : value loaded into every flop of the chain during reset. Using
//                 the idle level of the pin means releasing reset cannot by
//                 itself look like an edge.
// -----------------------------------------------------------------------------
module pong_edge_sync
  import pong_pkg::*;
#(
  parameter bit DETECT_RISE = 1'b1,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic edge_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // prev_q is one cycle behind sync_q, so a difference marks an edge.
  assign edge_o = DETECT_RISE ? (sync_q & ~prev_q) : (~sync_q & prev_q);

endmodule

// File: rtl/pong_game_seq.sv
// -----------------------------------------------------------------------------
// pong_game_seq
// Game sequencer for a two-player pong: serve hold, play, scoring and game over.
//   clk_i          : 25 MHz pixel clock
//   rst_n_i        : asynchronous active-low reset (forces IDLE)
//   Vsync_i        : VGA vsync, active low; each falling edge is one frame tick
//   Game_Start_i   : start request level; only its rising edge is used
//   Miss_P1_i      : pulse, ball passed player 1 (player 2 scores)
//   Miss_P2_i      : pulse, ball passed player 2 (player 1 scores)
//   Ball_Hold_o    : hold ball at screen centre
//   Ball_En_o      : enable ball motion
//   Serve_Dir_o    : serve direction (0 = toward P1, 1 = toward P2)
//   Paddle_En_o    : enable paddle motion
//   Score_P1_o     : player 1 score
//   Score_P2_o     : player 2 score
//   Game_Active_o  : high in SERVE and PLAY
//   Winner_o       : 00 none, 01 player 1, 10 player 2
// Parameters: WIN_SCORE (1..15), SERVE_FRAMES (1..255).
// -----------------------------------------------------------------------------
module pong_game_seq
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               Vsync_i,
  input  logic               Game_Start_i,
  input  logic               Miss_P1_i,
  input  logic               Miss_P2_i,
  output logic               Ball_Hold_o,
  output logic               Ball_En_o,
  output logic               Serve_Dir_o,
  output logic               Paddle_En_o,
  output logic [SCORE_W-1:0] Score_P1_o,
  output logic [SCORE_W-1:0] Score_P2_o,
  output logic               Game_Active_o,
  output logic [1:0]         Winner_o
);

  localparam logic [SCORE_W-1:0]     WIN_SCORE_C    = SCORE_W'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] SERVE_FRAMES_C = FRAME_CNT_W'(SERVE_FRAMES);
  localparam logic [SCORE_W-1:0]     SCORE_ONE      = SCORE_W'(1);

  logic frame_tick;
  logic start_edge;

  // Vsync idles high, so its chain resets high; start idles low.
  pong_edge_sync #(
    .DETECT_RISE (1'b0),
    .RESET_VAL   (1'b1)
  ) u_vsync_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .async_i (Vsync_i),
    .edge_o  (frame_tick)
  );

  pong_edge_sync #(
    .DETECT_RISE (1'b1),
    .RESET_VAL   (1'b0)
  ) u_start_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .async_i (Game_Start_i),
    .edge_o  (start_edge)
  );

  state_e                 state_q, state_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [SCORE_W-1:0]     score_p1_q, score_p1_d;
  logic [SCORE_W-1:0]     score_p2_q, score_p2_d;
  logic                   serve_dir_q, serve_dir_d;
  logic [1:0]             winner_q, winner_d;
  logic                   ball_hold_q, ball_hold_d;
  logic                   ball_en_q, ball_en_d;
  logic                   paddle_en_q, paddle_en_d;
  logic                   game_active_q, game_active_d;

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    score_p1_d  = score_p1_q;
    score_p2_d  = score_p2_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;

    case (state_q)
      IDLE, OVER: begin
        if (start_edge) begin
          score_p1_d  = '0;
          score_p2_d  = '0;
          serve_dir_d = 1'b1;
          winner_d    = WINNER_NONE;
          frame_cnt_d = '0;
          state_d     = SERVE;
        end
      end

      SERVE: begin
        // Leaving one cycle after the count is reached makes the hold span
        // exactly SERVE_FRAMES ticks.
        if (frame_cnt_q == SERVE_FRAMES_C) begin
          state_d = PLAY;
        end else if (frame_tick) begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end

      PLAY: begin
        if (Miss_P1_i && Miss_P2_i) begin
          // Simultaneous miss: nobody scores, serve flips to the other side.
          serve_dir_d = ~serve_dir_q;
          frame_cnt_d = '0;
          state_d     = SERVE;
        end else if (Miss_P2_i) begin
          score_p1_d  = score_p1_q + SCORE_ONE;
          serve_dir_d = 1'b1;
          if (score_p1_d == WIN_SCORE_C) begin
            winner_d = WINNER_P1;
            state_d  = OVER;
          end else begin
            frame_cnt_d = '0;
            state_d     = SERVE;
          end
        end else if (Miss_P1_i) begin
          score_p2_d  = score_p2_q + SCORE_ONE;
          serve_dir_d = 1'b0;
          if (score_p2_d == WIN_SCORE_C) begin
            winner_d = WINNER_P2;
            state_d  = OVER;
          end else begin
            frame_cnt_d = '0;
            state_d     = SERVE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Decoded from the next state so the registered outputs change on the
    // same edge as the state register.
    ball_hold_d   = (state_d != PLAY);
    ball_en_d     = (state_d == PLAY);
    paddle_en_d   = (state_d == SERVE) || (state_d == PLAY);
    game_active_d = (state_d == SERVE) || (state_d == PLAY);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      frame_cnt_q   <= '0;
      score_p1_q    <= '0;
      score_p2_q    <= '0;
      serve_dir_q   <= 1'b1;
      winner_q      <= WINNER_NONE;
      ball_hold_q   <= 1'b1;
      ball_en_q     <= 1'b0;
      paddle_en_q   <= 1'b0;
      game_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_cnt_q   <= frame_cnt_d;
      score_p1_q    <= score_p1_d;
      score_p2_q    <= score_p2_d;
      serve_dir_q   <= serve_dir_d;
      winner_q      <= winner_d;
      ball_hold_q   <= ball_hold_d;
      ball_en_q     <= ball_en_d;
      paddle_en_q   <= paddle_en_d;
      game_active_q <= game_active_d;
    end
  end

  assign Ball_Hold_o   = ball_hold_q;
  assign Ball_En_o     = ball_en_q;
  assign Serve_Dir_o   = serve_dir_q;
  assign Paddle_En_o   = paddle_en_q;
  assign Score_P1_o    = score_p1_q;
  assign Score_P2_o    = score_p2_q;
  assign Game_Active_o = game_active_q;
  assign Winner_o      = winner_q;

endmodule

// File: tb/tb_pong_game_seq.sv
// -----------------------------------------------------------------------------
// tb_pong_game_seq
// Drives two sequencers from the same pins: A plays to 2 points, B to 5, both
// hold the serve for 3 frames. Expected outputs come from an event-level model
// of the game rules (start, frame, miss, reset), not from cycle timing.
// -----------------------------------------------------------------------------
module tb_pong_game_seq;

  localparam int SERVE_N = 3;
  localparam int PH_IDLE = 0, PH_SERVE = 1, PH_PLAY = 2, PH_OVER = 3;

  logic clk = 1'b0;
  logic rst_n, vsync, start, miss_p1, miss_p2;

  logic       hold_w[2], en_w[2], dir_w[2], pad_w[2], act_w[2];
  logic [3:0] s1_w[2], s2_w[2];
  logic [1:0] win_w[2];

  always #20 clk = ~clk;

  pong_game_seq #(.WIN_SCORE(2), .SERVE_FRAMES(SERVE_N)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .Vsync_i(vsync), .Game_Start_i(start),
    .Miss_P1_i(miss_p1), .Miss_P2_i(miss_p2),
    .Ball_Hold_o(hold_w[0]), .Ball_En_o(en_w[0]), .Serve_Dir_o(dir_w[0]),
    .Paddle_En_o(pad_w[0]), .Score_P1_o(s1_w[0]), .Score_P2_o(s2_w[0]),
    .Game_Active_o(act_w[0]), .Winner_o(win_w[0])
  );

  pong_game_seq #(.WIN_SCORE(5), .SERVE_FRAMES(SERVE_N)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .Vsync_i(vsync), .Game_Start_i(start),
    .Miss_P1_i(miss_p1), .Miss_P2_i(miss_p2),
    .Ball_Hold_o(hold_w[1]), .Ball_En_o(en_w[1]), .Serve_Dir_o(dir_w[1]),
    .Paddle_En_o(pad_w[1]), .Score_P1_o(s1_w[1]), .Score_P2_o(s2_w[1]),
    .Game_Active_o(act_w[1]), .Winner_o(win_w[1])
  );

  // ---------------- reference model (one entry per instance) ----------------
  int    win_of[2] = '{2, 5};
  string nm[2]     = '{"A", "B"};
  int    m_ph[2], m_s1[2], m_s2[2], m_ticks[2], m_win[2];
  bit    m_dir[2];
  bit    start_lvl;

  int errors = 0;
  int checks = 0;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = PH_IDLE; m_s1[i] = 0; m_s2[i] = 0;
      m_ticks[i] = 0; m_win[i] = 0; m_dir[i] = 1'b1;
    end
  endfunction

  function automatic void model_start();
    for (int i = 0; i < 2; i++)
      if (m_ph[i] == PH_IDLE || m_ph[i] == PH_OVER) begin
        m_s1[i] = 0; m_s2[i] = 0; m_dir[i] = 1'b1; m_win[i] = 0;
        m_ticks[i] = 0; m_ph[i] = PH_SERVE;
      end
  endfunction

  function automatic void model_frame();
    for (int i = 0; i < 2; i++)
      if (m_ph[i] == PH_SERVE) begin
        m_ticks[i]++;
        if (m_ticks[i] == SERVE_N) m_ph[i] = PH_PLAY;
      end
  endfunction

  function automatic void model_miss(input bit p1, input bit p2);
    for (int i = 0; i < 2; i++) begin
      if (m_ph[i] != PH_PLAY || !(p1 || p2)) continue;
      m_ticks[i] = 0;
      m_ph[i] = PH_SERVE;
      if (p1 && p2) begin
        m_dir[i] = !m_dir[i];
      end else if (p2) begin
        m_s1[i]++; m_dir[i] = 1'b1;
        if (m_s1[i] == win_of[i]) begin m_ph[i] = PH_OVER; m_win[i] = 1; end
      end else begin
        m_s2[i]++; m_dir[i] = 1'b0;
        if (m_s2[i] == win_of[i]) begin m_ph[i] = PH_OVER; m_win[i] = 2; end
      end
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string step);
    for (int i = 0; i < 2; i++) begin
      string p;
      p = {step, "/", nm[i]};
      chk({p, " hold"},   32'(hold_w[i]), 32'(m_ph[i] != PH_PLAY));
      chk({p, " ball_en"}, 32'(en_w[i]),  32'(m_ph[i] == PH_PLAY));
      chk({p, " paddle"}, 32'(pad_w[i]),  32'(m_ph[i] == PH_SERVE || m_ph[i] == PH_PLAY));
      chk({p, " active"}, 32'(act_w[i]),  32'(m_ph[i] == PH_SERVE || m_ph[i] == PH_PLAY));
      chk({p, " dir"},    32'(dir_w[i]),  32'(m_dir[i]));
      chk({p, " score1"}, 32'(s1_w[i]),   32'(m_s1[i]));
      chk({p, " score2"}, 32'(s2_w[i]),   32'(m_s2[i]));
      chk({p, " winner"}, 32'(win_w[i]),  32'(m_win[i]));
    end
    $display("%-18s A: ph=%0d %0d:%0d dir=%0d win=%0d | B: ph=%0d %0d:%0d dir=%0d win=%0d",
             step, m_ph[0], m_s1[0], m_s2[0], m_dir[0], m_win[0],
             m_ph[1], m_s1[1], m_s2[1], m_dir[1], m_win[1]);
  endtask

  // ---------------- stimulus primitives ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input string step);
    @(negedge clk) vsync = 1'b0;
    cycles(4);
    vsync = 1'b1;
    cycles(4);
    model_frame();
    check_all(step);
  endtask

  task automatic frames(input int n, input string step);
    for (int k = 0; k < n; k++) frame(step);
  endtask

  task automatic miss(input bit p1, input bit p2, input string step);
    @(negedge clk) begin miss_p1 = p1; miss_p2 = p2; end
    @(negedge clk) begin miss_p1 = 1'b0; miss_p2 = 1'b0; end
    cycles(2);
    model_miss(p1, p2);
    check_all(step);
  endtask

  task automatic set_start(input bit v, input string step);
    @(negedge clk) start = v;
    cycles(5);
    if (v && !start_lvl) model_start();
    start_lvl = v;
    check_all(step);
  endtask

  // Reset asserted between clock edges; IDLE must show before the next edge.
  task automatic do_reset(input string step);
    @(negedge clk) begin start = 1'b0; vsync = 1'b1; end
    start_lvl = 1'b0;
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1 model_reset();
    check_all({step, "-async"});
    cycles(2);
    rst_n = 1'b1;
    cycles(4);
    check_all({step, "-release"});
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; vsync = 1'b1; start = 1'b0; miss_p1 = 1'b0; miss_p2 = 1'b0;
    start_lvl = 1'b0;
    model_reset();
    cycles(3);
    check_all("reset");
    rst_n = 1'b1;
    cycles(4);
    check_all("post-reset");

    // Start, then the serve hold must last exactly three frames.
    set_start(1'b1, "start");
    set_start(1'b0, "start-low");
    frames(SERVE_N, "serve-hold");

    // Player 2 scores; a miss during SERVE is ignored.
    miss(1'b1, 1'b0, "miss-p1");
    miss(1'b0, 1'b1, "miss-p2-in-serve");
    frames(SERVE_N, "serve");

    // Double miss: scores held, serve direction flips.
    miss(1'b1, 1'b1, "double-miss");
    frames(SERVE_N, "serve");

    // A reaches 2 points and ends; B continues.
    miss(1'b0, 1'b1, "p1-point");
    frames(SERVE_N, "serve");
    miss(1'b0, 1'b1, "p1-wins-A");
    frames(SERVE_N, "serve");
    miss(1'b0, 1'b1, "p1-point");
    frames(SERVE_N, "serve");
    miss(1'b1, 1'b0, "p2-point");
    frames(SERVE_N, "serve");

    // B is mid-PLAY at 3:2; reset must drop it to IDLE immediately.
    do_reset("reset-midplay");

    // Start held high across a whole game: no restart until it drops and rises.
    set_start(1'b1, "start-held");
    frames(SERVE_N, "serve");
    miss(1'b0, 1'b1, "p1-point");
    frames(SERVE_N, "serve");
    miss(1'b0, 1'b1, "p1-wins-A");
    set_start(1'b1, "start-still-high");
    frame("over-hold");
    set_start(1'b0, "start-drop");
    set_start(1'b1, "restart");
    set_start(1'b0, "start-low");

    // Random mix of frames, misses, start toggles and occasional resets.
    for (int n = 0; n < 90; n++) begin
      int op;
      op = $urandom_range(0, 9);
      case (op)
        0, 1, 2, 3: frame("rnd-frame");
        4:          miss(1'b1, 1'b0, "rnd-miss-p1");
        5:          miss(1'b0, 1'b1, "rnd-miss-p2");
        6:          miss(1'b1, 1'b1, "rnd-miss-both");
        7:          set_start(!start_lvl, "rnd-start");
        8:          miss(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd-miss");
        default: begin
          if ($urandom_range(0, 5) == 0) do_reset("rnd-reset");
          else frame("rnd-frame");
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pong_game_seq.md
PONG_GAME_SEQ -- requirements
Module: pong_game_seq

Interface
REQ-001 The module SHALL have parameter WIN_SCORE, default 9, meaning the points needed to win (range 1..15).
REQ-002 The module SHALL have parameter SERVE_FRAMES, default 60, meaning the number of frames the ball is held at centre before release (range 1..255).
REQ-003 Port clk_i, input, 1 bit: the single 25 MHz pixel clock; all logic is on its rising edge.
REQ-004 Port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port Vsync_i, input, 1 bit: VGA vertical sync, active low; one frame tick per falling edge.
REQ-006 Port Game_Start_i, input, 1 bit: start request, level; the module acts only on its rising edge.
REQ-007 Port Miss_P1_i, input, 1 bit: one-cycle pulse from the ball controller; the ball passed player 1's paddle, so player 2 scores.
REQ-008 Port Miss_P2_i, input, 1 bit: one-cycle pulse from the ball controller; the ball passed player 2's paddle, so player 1 scores.
REQ-009 Port Ball_Hold_o, output, 1 bit: forces the ball controller to hold the ball at screen centre.
REQ-010 Port Ball_En_o, output, 1 bit: enables ball motion.
REQ-011 Port Serve_Dir_o, output, 1 bit: initial ball direction; 0 = toward player 1, 1 = toward player 2.
REQ-012 Port Paddle_En_o, output, 1 bit: enables paddle motion.
REQ-013 Port Score_P1_o, output, 4 bits: player 1 score, unsigned.
REQ-014 Port Score_P2_o, output, 4 bits: player 2 score, unsigned.
REQ-015 Port Game_Active_o, output, 1 bit: high in SERVE and PLAY.
REQ-016 Port Winner_o, output, 2 bits: 00 = none, 01 = player 1, 10 = player 2; 11 is never driven.

Function
REQ-017 Vsync_i SHALL be registered through 2 flops; frame_tick is a one-cycle pulse on the detected falling edge (2-3 cycles after the pin edge).
REQ-018 Game_Start_i SHALL be registered through 2 flops; start_edge is a one-cycle pulse on the detected rising edge.
REQ-019 The FSM SHALL have four states: IDLE, SERVE, PLAY, OVER.
REQ-020 IDLE: Ball_Hold_o=1, Ball_En_o=0, Paddle_En_o=0; on start_edge, clear both scores, set Serve_Dir_o=1, set Winner_o=00, go to SERVE.
REQ-021 SERVE: Ball_Hold_o=1, Ball_En_o=0, Paddle_En_o=1; an 8-bit frame counter loads 0 on entry and increments on frame_tick.
REQ-022 SERVE SHALL go to PLAY on the cycle after the counter reaches SERVE_FRAMES, so the hold lasts exactly SERVE_FRAMES frame ticks.
REQ-023 PLAY: Ball_Hold_o=0, Ball_En_o=1, Paddle_En_o=1.
REQ-024 PLAY, Miss_P2_i alone: increment Score_P1_o, set Serve_Dir_o=1.
REQ-025 PLAY, Miss_P1_i alone: increment Score_P2_o, set Serve_Dir_o=0.
REQ-026 After a scoring miss, if the new score equals WIN_SCORE, go to OVER and set Winner_o; otherwise go to SERVE.
REQ-027 PLAY, Miss_P1_i and Miss_P2_i in the same cycle: no score change, Serve_Dir_o toggles, go to SERVE.
REQ-028 OVER: Ball_Hold_o=1, Ball_En_o=0, Paddle_En_o=0; scores and Winner_o are held; on start_edge, behave exactly as IDLE start (REQ-020).
REQ-029 Miss pulses SHALL be ignored outside PLAY; start_edge SHALL be ignored in SERVE and PLAY.
REQ-030 Score arithmetic SHALL be 4-bit unsigned and never wrap, since WIN_SCORE ≤ 15 ends the game first.
REQ-031 All outputs SHALL be registered; a state change appears on the outputs the cycle after the triggering event.

Reset
REQ-032 On rst_n_i low the module SHALL immediately enter IDLE, regardless of state, including mid-PLAY or mid-SERVE.
REQ-033 Reset values: scores 0, Winner_o=00, Serve_Dir_o=1, Ball_Hold_o=1, Ball_En_o=0, Paddle_En_o=0, Game_Active_o=0, frame counter 0.
REQ-034 Synchroniser flops SHALL reset to 1 (Vsync_i) and 0 (Game_Start_i).
REQ-035 Release of rst_n_i SHALL NOT by itself generate a frame_tick or start_edge.

Structure
REQ-036 Package pong_pkg SHALL hold the state enum (IDLE, SERVE, PLAY, OVER), the Winner encodings, and the score width constant 4.
REQ-037 One sub-module, pong_edge_sync, SHALL implement the 2-flop synchroniser plus edge detect, with a parameter selecting rise or fall; it is instantiated twice.

Verification
REQ-038 Reset mid-PLAY with scores 3:2: assert rst_n_i → same cycle shows IDLE outputs, scores 0:0, Winner_o=00.
REQ-039 Start from IDLE with SERVE_FRAMES=3: pulse Game_Start_i → Ball_Hold_o stays 1 for exactly 3 Vsync falling edges, then Ball_En_o=1.
REQ-040 PLAY, pulse Miss_P1_i → Score_P2_o=1, Serve_Dir_o=0, state SERVE; pulse Miss_P2_i during SERVE → no effect.
REQ-041 PLAY, Miss_P1_i and Miss_P2_i in the same cycle → scores unchanged, Serve_Dir_o toggles, state SERVE.
REQ-042 WIN_SCORE=2, two Miss_P2_i in separate PLAY phases → Score_P1_o=2, Winner_o=01, Paddle_En_o=0; Game_Start_i → scores 0:0, state SERVE.
REQ-043 Hold Game_Start_i high across a full game → only one start_edge; no restart from OVER until the input drops and rises again.
